// File: rtl/actuator_scheduler_if.sv
// Sensor request bundle into the actuator scheduler and the registered
// display/actuator drives back out of it.
interface actuator_scheduler_if;
  logic       SFD;
  logic       SRD;
  logic       SFA;
  logic       SW;
  logic       ST;
  logic [5:0] temperature;
  logic [2:0] display;
  logic       front_door;
  logic       rear_door;
  logic       alarm_buzzer;
  logic       window_buzzer;
  logic       heater;
  logic       cooler;
  logic       busy;

  modport master (
    output SFD, SRD, SFA, SW, ST, temperature,
    input  display, front_door, rear_door, alarm_buzzer, window_buzzer,
           heater, cooler, busy
  );

  modport slave (
    input  SFD, SRD, SFA, SW, ST, temperature,
    output display, front_door, rear_door, alarm_buzzer, window_buzzer,
           heater, cooler, busy
  );
endinterface

// File: rtl/actuator_scheduler.sv
// Round-robin arbiter sharing one actuator/display channel among five
// requesters, with bounded dwell, a one-cycle break-before-make gap and alarm preemption.
module actuator_scheduler #(
  parameter int unsigned DWELL      = 8,
  parameter int unsigned HEAT_BELOW = 10,
  parameter int unsigned COOL_ABOVE = 30,
  parameter bit          PREEMPT    = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  actuator_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [5:0] HEAT_T     = 6'(HEAT_BELOW);
  localparam logic [5:0] COOL_T     = 6'(COOL_ABOVE);
  localparam logic [7:0] DWELL_LOAD = 8'(DWELL - 1);

  state_t     state, state_nx;
  logic [2:0] ptr, ptr_nx;
  logic [2:0] slot, slot_nx;
  logic [2:0] code, code_nx;
  logic [7:0] cnt, cnt_nx;
  logic [2:0] display_q, display_nx;
  logic [5:0] act_q, act_nx;
  logic       busy_q, busy_nx;

  logic       cold, hot;
  logic [7:0] req;
  logic       pick_valid;
  logic [2:0] pick, pick_code;
  logic [3:0] idx;
  logic       preempt_hit, mode_flip;

  assign cold = bus.temperature < HEAT_T;
  assign hot  = bus.temperature > COOL_T;
  // Padded to 8 bits so a 3-bit slot index always lands inside the vector.
  assign req  = {3'b000, bus.ST & (hot | cold), bus.SW, bus.SFA, bus.SRD, bus.SFD};

  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    idx        = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      idx = 4'(ptr) + 4'(i);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (!pick_valid && req[idx[2:0]]) begin
        pick_valid = 1'b1;
        pick       = idx[2:0];
      end
    end
  end

  assign pick_code   = (pick == 3'd4) ? (cold ? 3'd5 : 3'd6) : pick + 3'd1;
  assign preempt_hit = PREEMPT && bus.SFA && (slot != 3'd2);
  assign mode_flip   = (slot == 3'd4) &&
                       (((code == 3'd5) && hot) || ((code == 3'd6) && cold));

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    slot_nx  = slot;
    code_nx  = code;
    cnt_nx   = cnt;
    unique case (state)
      IDLE, GAP: begin
        if (pick_valid) begin
          state_nx = GRANT;
          slot_nx  = pick;
          code_nx  = pick_code;
          cnt_nx   = DWELL_LOAD;
        end else begin
          state_nx = IDLE;
        end
      end
      GRANT: begin
        // Preemption outranks a coincident dwell expiry so the alarm goes next.
        if (preempt_hit) begin
          state_nx = GAP;
          ptr_nx   = 3'd2;
        end else if ((cnt == '0) || !req[slot] || mode_flip) begin
          state_nx = GAP;
          ptr_nx   = (slot == 3'd4) ? 3'd0 : slot + 3'd1;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase

    busy_nx    = (state_nx == GRANT);
    display_nx = busy_nx ? code_nx : 3'd0;
    act_nx     = (display_nx == 3'd0) ? 6'd0 : (6'd1 << (display_nx - 3'd1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      slot      <= '0;
      code      <= '0;
      cnt       <= '0;
      display_q <= '0;
      act_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      slot      <= slot_nx;
      code      <= code_nx;
      cnt       <= cnt_nx;
      display_q <= display_nx;
      act_q     <= act_nx;
      busy_q    <= busy_nx;
    end
  end

  assign bus.display       = display_q;
  assign bus.front_door    = act_q[0];
  assign bus.rear_door     = act_q[1];
  assign bus.alarm_buzzer  = act_q[2];
  assign bus.window_buzzer = act_q[3];
  assign bus.heater        = act_q[4];
  assign bus.cooler        = act_q[5];
  assign bus.busy          = busy_q;

endmodule
